wb_write_queue: RTL
===================

# wb_write_queue

Writeback queue that sits directly upstream of the register file. It accepts register writes (address + data) from the writeback stage over a valid/ready handshake and buffers them in a small FIFO. It drains at most one entry per cycle into the register file's `wr`/`rw`/`d` write port. Optionally it forwards pending (not yet committed) write data onto the read path so consumers never observe stale register values.

## Interface

- `DATA_WIDTH`, 32, register word width.
- `REG_DEPTH`, 32, number of architectural registers.
- `ADDR_WIDTH`, log2(REG_DEPTH) = 5, register address width.
- `RD_DEPTH`, 2, number of parallel read ports that are forwarded.
- `FIFO_DEPTH`, 4, queue entries; power of two, ≥2.

Ports:

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in_valid`  in  1  writeback request valid.
- `in_ready`  out  1  queue can accept; `(level < FIFO_DEPTH)` and `rst` released.
- `in_addr`  in  ADDR_WIDTH  destination register.
- `in_data`  in  DATA_WIDTH  write data.
- `hold`  in  1  1 = suspend draining; queue still accepts while not full.
- `wr`  out  1  register-file write enable, registered.
- `rw`  out  ADDR_WIDTH  register-file write address, registered.
- `d`  out  DATA_WIDTH  register-file write data, registered.
- `rr`  in  ADDR_WIDTH*RD_DEPTH  read addresses, vectorized; the same lines feed the register file.
- `rf_q`  in  DATA_WIDTH*RD_DEPTH  read data returned by the register file.
- `q`  out  DATA_WIDTH*RD_DEPTH  read data after forwarding, vectorized.
- `level`  out  log2(FIFO_DEPTH)+1  current occupancy.

## Operation

- **Push.** A push occurs when `in_valid && in_ready` at a rising edge.
  - `in_addr == 0`: the handshake completes but nothing is stored. Register 0 is never written.
- **Pop.** A pop occurs at an edge where `hold == 0` and `level > 0`.
  - The head entry moves into `rw`/`d` and `wr` is set to 1.
  - At every other edge, `wr` is set to 0 and `rw`/`d` hold their values.
- **Push and pop in the same edge.** Both take effect; `level` is unchanged.
- **`in_ready` is not combinationally dependent on pop.** When full, a same-cycle pop does not allow a push.
- **Ordering.** Strict FIFO. Multiple pending writes to the same address commit in arrival order; the youngest value wins.
- **Pointers.** Read and write pointers wrap modulo FIFO_DEPTH. Full and empty are derived from `level`, not from pointer equality.
- **Forwarding** (per read port i, only when the feature is compiled in):
  - If `rr_i != 0` and it matches any valid FIFO entry, `q_i` takes the youngest matching entry's data.
  - Otherwise, if `wr == 1 && rw == rr_i`, `q_i` takes `d`.
  - Otherwise `q_i = rf_q_i`.
  - Data being pushed in the current cycle (`in_data`) is not forwarded.
- **Reset (asynchronous, `rst` = 0).**
  - Clears `level` and both pointers.
  - `wr` = 0, `rw` = 0, `d` = 0; `in_ready` = 0.
  - Pending entries are discarded with no commit, including when reset asserts mid-drain.
  - After `rst` rises, `in_ready` = 1.

## Timing

- **Enqueue-to-commit latency** (empty queue, `hold == 0`):
  - Push at edge k, pop at edge k+1, so `wr` = 1 during the cycle after edge k+1.
  - The register file captures the data at edge k+2.
- **Throughput:** one push and one pop per cycle, sustained.
- **`wr` pulse:** high for exactly one cycle per popped entry; back-to-back pops keep `wr` high continuously.
- **Forwarding path:** purely combinational from `rr`, FIFO contents, `wr`/`rw`/`d` and `rf_q` to `q`. No added latency.
- **`hold`:** sampled at the edge. Asserting it in cycle n suppresses the pop at the end of cycle n, and `wr` = 0 in the following cycle.

## Configuration

- **`WB_FORWARD_EN` defined:** forwarding comparators and the priority select are compiled in, as described under Operation.
- **`WB_FORWARD_EN` undefined:**
  - `q = rf_q` directly and no comparators exist; `rr` is unused internally.
  - Consumers must stall on pending writes themselves.
  - All other behaviour is identical.

## Test plan

- **Single write:** reset, then push addr 5 / 0xDEADBEEF with `hold` = 0.
  - `wr` = 1, `rw` = 5, `d` = 0xDEADBEEF in the cycle after the next edge.
  - `wr` = 0 afterwards; `level` returns to 0.
- **Fill under hold:** `hold` = 1, push addrs 1,2,3,4 with data 0x11..0x44.
  - `level` = 4 and `in_ready` = 0; a fifth push is not accepted.
  - Release `hold`: `wr` is high for 4 consecutive cycles with `rw` = 1,2,3,4 in order.
- **Zero register:** push addr 0 / 0xFFFFFFFF.
  - `in_ready` stays 1, `level` stays 0, `wr` never asserts.
- **Forwarding priority** (`WB_FORWARD_EN`): `hold` = 1, push addr 7 / 0xA then addr 7 / 0xB.
  - Set `rr_0` = 7 and `rf_q_0` = 0x0: `q_0` = 0xB.
  - Set `rr_1` = 3 and `rf_q_1` = 0x33: `q_1` = 0x33.
  - Without the macro: `q_0` = 0x0.
- **Simultaneous push/pop and wrap:** stream 12 pushes back-to-back with `hold` = 0.
  - `level` is never above 1 and `wr` is continuous for 12 cycles.
  - Data arrives in order, exercising pointer wrap three times.
- **Reset mid-operation:** with `level` = 3 and `wr` = 1, drive `rst` = 0 asynchronously between edges.
  - `wr`, `level` and `in_ready` go to 0 immediately.
  - After release, no stale entry is ever written.

Source files
------------

// File: rtl/wb_write_queue.sv
// Writeback queue feeding the register-file write port. It buffers register writes in a small FIFO and drains one per cycle.
// Define WB_FORWARD_EN to forward pending write data onto the read path.
module wb_write_queue #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_DEPTH  = 32,
  parameter int ADDR_WIDTH = $clog2(REG_DEPTH),
  parameter int RD_DEPTH   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [ADDR_WIDTH-1:0]          in_addr,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic                           hold,
  output logic                           wr,
  output logic [ADDR_WIDTH-1:0]          rw,
  output logic [DATA_WIDTH-1:0]          d,
  input  logic [ADDR_WIDTH*RD_DEPTH-1:0] rr,
  input  logic [DATA_WIDTH*RD_DEPTH-1:0] rf_q,
  output logic [DATA_WIDTH*RD_DEPTH-1:0] q,
  output logic [$clog2(FIFO_DEPTH):0]    level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] rw_q, rw_d;
  logic [DATA_WIDTH-1:0] d_q, d_d;

  logic push, store, pop;

  // in_ready is gated by reset directly so it drops the moment reset asserts.
  assign in_ready = rst && (level_q < LVL_W'(FIFO_DEPTH));
  assign wr       = wr_q;
  assign rw       = rw_q;
  assign d        = d_q;
  assign level    = level_q;

  always_comb begin
    push     = in_valid && in_ready;
    store    = push && (in_addr != '0);
    pop      = !hold && (level_q != '0);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    wr_d     = 1'b0;
    rw_d     = rw_q;
    d_d      = d_q;
    if (store) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      wr_d     = 1'b1;
      rw_d     = addr_mem[rd_ptr_q];
      d_d      = data_mem[rd_ptr_q];
    end
    level_d = level_q + LVL_W'(store) - LVL_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      wr_q     <= 1'b0;
      rw_q     <= '0;
      d_q      <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      wr_q     <= wr_d;
      rw_q     <= rw_d;
      d_q      <= d_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      addr_mem[wr_ptr_q] <= in_addr;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

`ifdef WB_FORWARD_EN
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] fwd;
  logic [PTR_W-1:0]      idx;

  // Entries are scanned oldest to youngest so the last match (youngest) wins.
  always_comb begin
    q       = rf_q;
    rd_addr = '0;
    fwd     = '0;
    idx     = '0;
    for (int unsigned i = 0; i < RD_DEPTH; i++) begin
      rd_addr = rr[i*ADDR_WIDTH +: ADDR_WIDTH];
      fwd     = rf_q[i*DATA_WIDTH +: DATA_WIDTH];
      if (wr_q && (rw_q == rd_addr)) begin
        fwd = d_q;
      end
      for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
        idx = rd_ptr_q + PTR_W'(k);
        if ((rd_addr != '0) && (LVL_W'(k) < level_q) && (addr_mem[idx] == rd_addr)) begin
          fwd = data_mem[idx];
        end
      end
      q[i*DATA_WIDTH +: DATA_WIDTH] = fwd;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^rr;
  assign q         = rf_q;
`endif

endmodule
